// File: rtl/uart_rx_mapped.sv
// uart_rx_mapped: 8N1 serial receiver with a small byte FIFO read via the IO page.
// rxd is synchronised, each frame is sampled at mid-bit using a down-counter, and
// complete bytes are queued for the processor, with sticky overrun / framing flags.
module uart_rx_mapped #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 1000000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  input  logic       rstrb,
  input  logic       clear_err,
  output logic [7:0] rdata,
  output logic       rx_valid,
  output logic       overrun,
  output logic       frame_err
);

  localparam int N  = CLK_FREQ_HZ / BAUD_RATE;
  localparam int H  = N / 2;
  localparam int CW = $clog2(N);
  localparam int AW = $clog2(FIFO_DEPTH);

  generate
    if (N < 4) begin : g_bad_rate
      $error("uart_rx_mapped: CLK_FREQ_HZ / BAUD_RATE must be at least 4");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_rx_mapped: FIFO_DEPTH must be a power of two, at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic          sync1_r;
  logic          rxs_r;
  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] cnt_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shreg_r;
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [7:0]    rdata_r;
  logic          overrun_r;
  logic          frame_err_r;

  logic cnt_zero_s;
  logic load_half_s;
  logic load_full_s;
  logic shift_s;
  logic clr_idx_s;
  logic push_s;
  logic ferr_set_s;
  logic fifo_empty_s;
  logic fifo_full_s;
  logic pop_s;
  logic push_ok_s;
  logic ovr_set_s;

  assign cnt_zero_s   = (cnt_r == {CW{1'b0}});
  assign fifo_empty_s = (count_r == {(AW + 1){1'b0}});
  assign fifo_full_s  = (count_r == (AW + 1)'(FIFO_DEPTH));
  assign pop_s        = rstrb & ~fifo_empty_s;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok_s    = push_s & (~fifo_full_s | pop_s);
  assign ovr_set_s    = push_s & fifo_full_s & ~pop_s;

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
    end else begin
      sync1_r <= rxd;
      rxs_r   <= sync1_r;
    end
  end

  // Receiver FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Receiver next-state logic and per-cycle datapath strobes.
  always_comb begin
    state_s     = state_r;
    load_half_s = 1'b0;
    load_full_s = 1'b0;
    shift_s     = 1'b0;
    clr_idx_s   = 1'b0;
    push_s      = 1'b0;
    ferr_set_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rxs_r) begin
          load_half_s = 1'b1;
          state_s     = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_zero_s) begin
          if (!rxs_r) begin
            load_full_s = 1'b1;
            clr_idx_s   = 1'b1;
            state_s     = ST_DATA;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_zero_s) begin
          shift_s     = 1'b1;
          load_full_s = 1'b1;
          if (bit_idx_r == 3'd7) begin
            state_s = ST_STOP;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (cnt_zero_s) begin
          if (rxs_r) begin
            push_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            ferr_set_s = 1'b1;
            state_s    = ST_BREAK;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (rxs_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BREAK;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Bit-timing down-counter, data bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_r     <= {CW{1'b0}};
      bit_idx_r <= 3'd0;
      shreg_r   <= 8'h00;
    end else begin
      if (load_half_s) begin
        cnt_r <= CW'(H - 1);
      end else if (load_full_s) begin
        cnt_r <= CW'(N - 1);
      end else if (!cnt_zero_s) begin
        cnt_r <= cnt_r - CW'(1);
      end
      if (clr_idx_s) begin
        bit_idx_r <= 3'd0;
      end else if (shift_s) begin
        bit_idx_r <= bit_idx_r + 3'd1;
      end
      if (shift_s) begin
        shreg_r <= {rxs_r, shreg_r[7:1]};
      end
    end
  end

  // FIFO byte storage; slots are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= shreg_r;
    end
  end

  // FIFO pointers, occupancy and the registered read port.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
      rdata_r  <= 8'h00;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
      if (rstrb) begin
        rdata_r <= pop_s ? mem_r[rd_ptr_r] : 8'h00;
      end
    end
  end

  // Sticky error flags; a new error event wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (ovr_set_s) begin
        overrun_r <= 1'b1;
      end else if (clear_err) begin
        overrun_r <= 1'b0;
      end
      if (ferr_set_s) begin
        frame_err_r <= 1'b1;
      end else if (clear_err) begin
        frame_err_r <= 1'b0;
      end
    end
  end

  assign rdata     = rdata_r;
  assign rx_valid  = ~fifo_empty_s;
  assign overrun   = overrun_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_uart_rx_mapped.sv
// Testbench for uart_rx_mapped: serial frames are driven on rxd, a byte-level
// reference FIFO predicts read results, and a monitor checks each read response.
`timescale 1ns/1ps
module tb_uart_rx_mapped;

  localparam int CLK_HZ = 100000000;
  localparam int BAUD   = 1000000;
  localparam int N      = CLK_HZ / BAUD;
  localparam int H      = N / 2;
  localparam int DEPTH  = 4;
  // Negedge index (counted from the start-bit falling edge) at which a pushed byte is visible.
  localparam int PUSH_J = H + 9 * N + 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rxd = 1'b1;
  logic       rstrb = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] rdata;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;

  uart_rx_mapped #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rxd      (rxd),
    .rstrb    (rstrb),
    .clear_err(clear_err),
    .rdata    (rdata),
    .rx_valid (rx_valid),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       valid;
  } rd_exp_t;

  rd_exp_t    exp_q[$];
  logic [7:0] ref_q[$];
  logic       exp_overrun = 1'b0;
  logic       exp_frame = 1'b0;
  int         checks = 0;
  int         errors = 0;
  logic       rd_seen = 1'b0;
  rd_exp_t    mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Remember that a read was issued so its response is checked one cycle later.
  always @(posedge clk) rd_seen <= rstrb;

  // Monitor: pops the expected read response and compares it with the DUT.
  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_unexpected: got rdata %0h with no expected read", rdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rdata", 32'(rdata), 32'(mon_e.data));
        chk("rx_valid_after_read", 32'(rx_valid), 32'(mon_e.valid));
      end
    end
  end

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read();
    rd_exp_t e;
    if (ref_q.size() > 0) e.data = ref_q.pop_front();
    else e.data = 8'h00;
    e.valid = (ref_q.size() > 0);
    exp_q.push_back(e);
    rstrb = 1'b1;
    @(negedge clk);
    rstrb = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    exp_overrun = 1'b0;
    exp_frame = 1'b0;
    @(negedge clk);
  endtask

  // One 8N1 frame; stop_low>0 holds the stop bit low for that many bit times.
  // rd_at_push issues a read in the very cycle the byte is pushed.
  task automatic send_byte(input logic [7:0] b, input int stop_low, input bit rd_at_push);
    logic [9:0] fr;
    bit         timed;
    bit         ftimed;
    int         j;
    int         len;
    rd_exp_t    e;
    fr = {1'b1, b, 1'b0};
    timed = (ref_q.size() == 0) && (stop_low == 0);
    ftimed = (stop_low > 0) && !exp_frame;
    j = 0;
    for (int k = 0; k < 10; k++) begin
      rxd = (k == 9 && stop_low > 0) ? 1'b0 : fr[k];
      len = (k == 9 && stop_low > 0) ? stop_low * N : N;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        j++;
        if (j == PUSH_J - 1) begin
          if (timed) chk("rx_valid_at_stop_sample", 32'(rx_valid), 32'd0);
          if (ftimed) chk("frame_err_at_stop_sample", 32'(frame_err), 32'd0);
          if (rd_at_push) begin
            e.data = (ref_q.size() > 0) ? ref_q.pop_front() : 8'h00;
            e.valid = 1'b1;
            exp_q.push_back(e);
            rstrb = 1'b1;
          end
        end
        if (j == PUSH_J) begin
          rstrb = 1'b0;
          if (timed) chk("rx_valid_after_stop_sample", 32'(rx_valid), 32'd1);
          if (ftimed) chk("frame_err_after_stop_sample", 32'(frame_err), 32'd1);
        end
      end
    end
    if (stop_low > 0) begin
      rxd = 1'b1;
      repeat (N) @(negedge clk);
      exp_frame = 1'b1;
    end else if (ref_q.size() == DEPTH) begin
      exp_overrun = 1'b1;
    end else begin
      ref_q.push_back(b);
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_overrun"}, 32'(overrun), 32'(exp_overrun));
    chk({tag, "_frame_err"}, 32'(frame_err), 32'(exp_frame));
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'(ref_q.size() != 0));
  endtask

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] fr;
    int         n;
    int         m;
    // Reset state.
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rdata", 32'(rdata), 32'h0);
    chk_flags("reset");
    resetn = 1'b1;
    idle(20);

    // Single byte, exact rx_valid timing, then read.
    send_byte(8'h55, 0, 1'b0);
    idle(5);
    do_read();
    chk_flags("t55");

    // Back-to-back frames, then one read past empty.
    send_byte(8'hA3, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'hFF, 0, 1'b0);
    idle(5);
    repeat (4) do_read();

    // Overrun, clear, then push+pop while full.
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 0, 1'b0);
    idle(5);
    chk_flags("overrun_set");
    pulse_clear();
    chk_flags("overrun_clear");
    send_byte(8'h06, 0, 1'b1);
    idle(5);
    chk_flags("full_push_pop");
    repeat (4) do_read();

    // Push and read on an empty FIFO in the same cycle.
    send_byte(8'h99, 0, 1'b1);
    idle(5);
    do_read();

    // Long break: one framing error, no byte.
    send_byte(8'h3C, 3, 1'b0);
    idle(10);
    chk_flags("break");
    pulse_clear();
    idle(200);
    chk_flags("break_cleared");
    send_byte(8'h42, 0, 1'b0);
    idle(5);
    do_read();

    // Short glitch on an idle line.
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    idle(300);
    chk_flags("glitch");

    // Reset in the middle of data bit 4 with a byte still queued.
    send_byte(8'h11, 0, 1'b0);
    idle(5);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 5; k++) begin
      rxd = fr[k];
      repeat ((k == 4) ? H : N) @(negedge clk);
    end
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    ref_q.delete();
    exp_overrun = 1'b0;
    exp_frame = 1'b0;
    chk("midreset_rdata", 32'(rdata), 32'h0);
    chk_flags("midreset");
    resetn = 1'b1;
    idle(1500);
    send_byte(8'h7E, 0, 1'b0);
    idle(5);
    do_read();
    chk_flags("after_reset");

    // Randomised bursts, gaps and reads against the reference FIFO.
    for (int r = 0; r < 5; r++) begin
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 300)));
        send_byte(8'($urandom_range(0, 255)), 0, ($urandom_range(0, 7) == 0));
      end
      idle(5);
      chk_flags("rand_burst");
      m = int'($urandom_range(0, 7));
      for (int i = 0; i < m; i++) do_read();
      if ($urandom_range(0, 1) == 1) pulse_clear();
      chk_flags("rand_after_reads");
    end

    idle(5);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_mapped.md
# uart_rx_mapped

Memory-mapped UART receiver: the receive-side counterpart of the SOC's transmit-only UART emitter. It samples the asynchronous RXD pin, deserialises 8N1 frames, buffers received bytes in a small FIFO and exposes them to the processor through the IO page. Firmware uses it for console input and serial bootloading.

## Interface
- CLK_FREQ_HZ, default 100000000: system clock frequency.
- BAUD_RATE, default 1000000: line rate.
- FIFO_DEPTH, default 4: byte slots; power of two, at least 2.
- clk  input  1  system clock.
- resetn  input  1  reset, synchronous, active-low.
- rxd  input  1  serial line; asynchronous, idle high.
- rstrb  input  1  pop request from the IO decoder (isIO & mem_rstrb & data-word select).
- clear_err  input  1  clears overrun and frame_err.
- rdata  output  8  popped byte, registered.
- rx_valid  output  1  FIFO not empty.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- frame_err  output  1  sticky: the stop bit was sampled low.

## Operation
- N = CLK_FREQ_HZ / BAUD_RATE, integer-truncated; elaboration fails if N < 4. H = N/2, truncated.
- rxd passes through a 2-flop synchroniser (both flops reset to 1). All logic uses the synchronised value rxs.
- One down-counter, ceil(log2 N) bits wide, plus a 3-bit bit index and an 8-bit shift register.
- FSM states:
  - IDLE: on rxs==0, load counter with H-1 and go to START.
  - START: at counter==0, sample rxs. If 0, load N-1, clear the bit index and go to DATA. If 1 (glitch), return to IDLE with no side effects.
  - DATA: at counter==0, shift rxs into bit 7 of the shift register (LSB first, so shreg <= {rxs, shreg[7:1]}) and reload N-1. After bit index 7, go to STOP.
  - STOP:
    - At counter==0 with rxs==1: push shreg into the FIFO and go to IDLE.
    - At counter==0 with rxs==0: set frame_err, discard the byte and go to BREAK.
  - BREAK: wait for rxs==1, then go to IDLE. A long break therefore produces exactly one frame_err and no bytes.
- FIFO: circular buffer with read and write pointers and a count of log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
  - Push when full: byte dropped, FIFO contents unchanged, overrun set.
  - Push and pop in the same cycle while full: the pop frees a slot, the push succeeds, no overrun.
- Read: on rstrb with FIFO non-empty, rdata <= head and the FIFO pops. On rstrb with FIFO empty, rdata <= 8'h00 and nothing pops.
  - A push and an rstrb in the same cycle on an empty FIFO: the read returns 8'h00 and the pushed byte is stored.
- clear_err clears both sticky flags. If clear_err coincides with a new error event, the set wins.
- Reset (resetn low at a clk edge) forces: FSM to IDLE, counter and bit index to 0, FIFO emptied, rdata=8'h00, rx_valid=0, overrun=0, frame_err=0, synchroniser to 1. A reset mid-frame abandons the frame. After reset is released, a line that is still low goes IDLE -> START, and a frame already in progress may be mis-framed; this is acceptable.

## Timing
- Synchroniser latency: 2 cycles from the pin to rxs.
- Let T0 be the cycle in which IDLE sees rxs==0.
  - Start bit sampled at T0+H.
  - Data bit i (i = 0..7) sampled at T0+H+(i+1)·N.
  - Stop bit sampled at T0+H+9·N.
- rx_valid rises at T0+H+9·N+1.
- The FSM re-enters IDLE the cycle after the stop sample. Back-to-back frames with no idle gap are received correctly as long as the transmitter rate is within about ±4% of BAUD_RATE.
- rdata is valid the cycle after rstrb and holds until the next rstrb. rx_valid and the FIFO count update in that same cycle.
- overrun and frame_err assert the cycle after the offending stop-bit sample.

## Test plan
- Default parameters (N=100): drive frame 0x55 on rxd with a bit time of 100 cycles -> rx_valid rises 1 cycle after the stop sample; rstrb -> rdata=8'h55 the next cycle, rx_valid=0.
- Send 0xA3, 0x00, 0xFF back-to-back with no idle gap, then pulse rstrb three times -> rdata reads 8'hA3, 8'h00, 8'hFF in order; a fourth rstrb -> 8'h00 with rx_valid=0.
- Send 5 bytes (0x01..0x05) with no reads, FIFO_DEPTH=4 -> overrun=1; reads return 0x01..0x04. clear_err -> overrun=0.
- Send 0x3C with the stop bit held low for 3 bit times -> frame_err=1, rx_valid stays 0, exactly one error and no bytes. Then send 0x42 -> rdata=8'h42.
- Drive a 20-cycle low glitch on idle rxd -> no FSM progress past START, rx_valid=0, no flags set.
- Assert resetn=0 during data bit 4 of a frame, release it, then send 0x7E -> clean capture of 0x7E, no flags set.
